fact_engine: RTL and testbench
==============================

FACT_ENGINE -- requirements
Module: fact_engine

Interface
REQ-001 The block SHALL have parameter NW, default 4, giving the operand width in bits (n range 0..2^NW-1).
REQ-002 The block SHALL have parameter RW, default 32, giving the result width in bits, with RW <= 32.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the depth of each FIFO, a power of 2 and >= 2.
REQ-004 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- A  in  3  register address.
- WE  in  1  write enable, qualifies WD at A.
- WD  in  32  write data.
- RD  out  32  read data, combinational from A.
- IRQ  out  1  interrupt request.

Function
REQ-005 The block SHALL decode the address map as follows; unlisted addresses read 0 and ignore writes:
- A=0: write pushes WD[NW-1:0] into the request FIFO; read returns the request FIFO occupancy.
- A=1: read returns status {26'b0, drop, busy, req_full, req_empty, res_full, res_empty}, bit 0 = res_empty.
- A=2: read returns the head value of the result FIFO, zero-extended; returns 0 when the FIFO is empty.
- A=3: read returns the head error flag in bit 0; any write pops the result FIFO.
- A=4: control register, bit0 IE, bit1 write-1-to-clear drop; read returns {31'b0, IE}.
REQ-006 A push while the request FIFO is full SHALL be discarded and SHALL set the sticky drop flag.
REQ-007 A pop while the result FIFO is empty SHALL be ignored with no state change.
REQ-008 Both FIFOs SHALL support a push and a pop in the same cycle, including when full or empty (full: the pop frees space, so the push is accepted; empty: the push is accepted and the pop is ignored).
REQ-009 The FSM SHALL have states IDLE, CALC and DONE, and busy = (state != IDLE).
REQ-010 In IDLE, if the request FIFO is non-empty, the FSM SHALL pop the request, set acc=1, cnt=n, clear err and enter CALC.
REQ-011 In CALC, if cnt <= 1 the FSM SHALL enter DONE; otherwise it SHALL set acc=acc*cnt and cnt=cnt-1 (one multiply per cycle).
REQ-012 Each product SHALL be formed at 2*RW bits; a nonzero upper half SHALL set err and go to DONE immediately.
REQ-013 In DONE, if the result FIFO is not full, the FSM SHALL push {err, err ? 0 : acc[RW-1:0]} and return to IDLE; otherwise it SHALL hold in DONE, with acc stable, until space frees.
REQ-014 For n=0 and n=1 the result SHALL be 1 with no error.
REQ-015 Latency: with the FSM idle and result space free, the result SHALL become readable max(n,1)+2 clock edges after the push edge, or earlier on overflow.
REQ-016 Requests SHALL complete strictly in FIFO order, with one calculation in flight.

Reset
REQ-017 On rst=1 at a clock edge, both FIFOs SHALL become empty, FSM=IDLE, acc=0, cnt=0, err=0, drop=0, IE=0 and IRQ=0.
REQ-018 Reset during CALC or DONE SHALL abandon the calculation with no result pushed.
REQ-019 rst SHALL take priority over simultaneous writes.

Configuration
REQ-020 Macro FACT_ENGINE_IRQ_EN defined: IRQ SHALL be registered as IE & ~res_empty, asserting one cycle after the condition becomes true.
REQ-021 Macro FACT_ENGINE_IRQ_EN undefined: IRQ SHALL be tied to 0, IE SHALL not be implemented, and A=4 SHALL read 0.

Verification
REQ-022 The bench SHALL cover each scenario below:
- Reset, write 5 to A=0, wait 7 edges -> A=2 reads 120, A=3 reads 0, A=1 res_empty=0.
- Push 0, then 1, then 12 -> results in order 1, 1, 479001600, all err=0.
- Push 13 (RW=32) -> A=3 reads 1, A=2 reads 0.
- Push 5 more requests than the FIFOs and the FSM can absorb without any pops -> drop=1; FSM holds in DONE while res_full=1; pop frees space and processing resumes; write 2 to A=4 clears drop.
- Same-cycle push while the request FIFO is full and the FSM pops -> request accepted, drop stays 0.
- With FACT_ENGINE_IRQ_EN, IE=1, push 3 -> IRQ=1 after the result arrives; pop -> IRQ=0 next cycle; assert rst mid-CALC -> no result pushed, all status bits reset.

Source files
------------

// File: rtl/fact_engine_if.sv
// Register bus for fact_engine: 3-bit address, write strobe/data,
// combinational read data and the interrupt line.
interface fact_engine_if;
    logic [2:0]  A;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    modport master (output A, WE, WD, input RD, IRQ);
    modport slave  (input A, WE, WD, output RD, IRQ);
endinterface

// File: rtl/fact_engine.sv
// fact_engine: register-mapped factorial accelerator.
// Requests (n) are queued in a request FIFO, computed one multiply per cycle
// by a small FSM, and results {err, value} are queued in a result FIFO.
// Optional feature: define FACT_ENGINE_IRQ_EN to implement the IE bit and a
// registered interrupt (IE & result-available). Without it, IRQ is 0.
module fact_engine #(
    parameter int NW    = 4,
    parameter int RW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fact_engine_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [RW-1:0]   acc;
    logic [NW-1:0]   cnt;
    logic            err;
    logic            drop;
    logic            ie_rd;

    // Request FIFO storage
    logic [NW-1:0]   req_mem [DEPTH];
    logic [AW-1:0]   req_wp, req_rp;
    logic [CW-1:0]   req_cnt;
    // Result FIFO storage: bit RW is the error flag
    logic [RW:0]     res_mem [DEPTH];
    logic [AW-1:0]   res_wp, res_rp;
    logic [CW-1:0]   res_cnt;

    logic req_empty, req_full, res_empty, res_full, busy;
    logic req_wr, req_push, req_pop, res_push, res_pop;
    logic [2*RW-1:0] prod;
    logic            prod_ovf;
    logic [RW:0]     res_head;
    logic            unused_wd;

    assign req_empty = (req_cnt == '0);
    assign req_full  = (req_cnt == CW'(DEPTH));
    assign res_empty = (res_cnt == '0);
    assign res_full  = (res_cnt == CW'(DEPTH));
    assign busy      = (state != IDLE);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign req_pop   = (state == IDLE) && !req_empty;
    assign req_wr    = bus.WE && (bus.A == 3'd0);
    assign req_push  = req_wr && (!req_full || req_pop);
    assign res_pop   = bus.WE && (bus.A == 3'd3) && !res_empty;
    assign res_push  = (state == DONE) && (!res_full || res_pop);

    assign prod      = (2*RW)'(acc) * (2*RW)'(cnt);
    assign prod_ovf  = |prod[2*RW-1:RW];
    assign res_head  = res_mem[res_rp];
    assign unused_wd = ^bus.WD;

    // Request FIFO pointers, occupancy and storage
    always_ff @(posedge clk) begin
        if (rst) begin
            req_wp  <= '0;
            req_rp  <= '0;
            req_cnt <= '0;
        end else begin
            if (req_push) begin
                req_mem[req_wp] <= bus.WD[NW-1:0];
                req_wp          <= req_wp + AW'(1);
            end
            if (req_pop)
                req_rp <= req_rp + AW'(1);
            req_cnt <= req_cnt + CW'(req_push) - CW'(req_pop);
        end
    end

    // Result FIFO pointers, occupancy and storage
    always_ff @(posedge clk) begin
        if (rst) begin
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else begin
            if (res_push) begin
                res_mem[res_wp] <= {err, err ? '0 : acc};
                res_wp          <= res_wp + AW'(1);
            end
            if (res_pop)
                res_rp <= res_rp + AW'(1);
            res_cnt <= res_cnt + CW'(res_push) - CW'(res_pop);
        end
    end

    // Calculation FSM: one multiply per CALC cycle, DONE holds until space
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!req_empty) begin
                    acc   <= RW'(1);
                    cnt   <= req_mem[req_rp];
                    err   <= 1'b0;
                    state <= CALC;
                end
                CALC: begin
                    if (cnt <= NW'(1)) begin
                        state <= DONE;
                    end else if (prod_ovf) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc <= prod[RW-1:0];
                        cnt <= cnt - NW'(1);
                    end
                end
                DONE: if (res_push) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky drop flag: set on a discarded push, cleared by writing bit1 at A=4
    always_ff @(posedge clk) begin
        if (rst)
            drop <= 1'b0;
        else if (req_wr && req_full && !req_pop)
            drop <= 1'b1;
        else if (bus.WE && bus.A == 3'd4 && bus.WD[1])
            drop <= 1'b0;
    end

`ifdef FACT_ENGINE_IRQ_EN
    logic ie, irq;

    // Interrupt enable and registered interrupt (one cycle behind the FIFO)
    always_ff @(posedge clk) begin
        if (rst) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (bus.WE && bus.A == 3'd4)
                ie <= bus.WD[0];
            irq <= ie & ~res_empty;
        end
    end

    assign bus.IRQ = irq;
    assign ie_rd   = ie;
`else
    assign bus.IRQ = 1'b0;
    assign ie_rd   = 1'b0;
`endif

    // Combinational read mux
    always_comb begin
        bus.RD = '0;
        case (bus.A)
            3'd0: bus.RD = 32'(req_cnt);
            3'd1: bus.RD = {26'b0, drop, busy, req_full, req_empty, res_full, res_empty};
            3'd2: if (!res_empty) bus.RD = 32'(res_head[RW-1:0]);
            3'd3: if (!res_empty) bus.RD = {31'b0, res_head[RW]};
            3'd4: bus.RD = {31'b0, ie_rd};
            default: bus.RD = '0;
        endcase
    end
endmodule

// File: tb/tb_fact_engine.sv
// Testbench for fact_engine: directed table, corner sequences, and random
// traffic compared against a plain-arithmetic factorial model.
module tb_fact_engine;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #10 clk = ~clk;

    fact_engine_if bus();
    fact_engine #(.NW(4), .RW(32), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          n;
        logic [31:0] val;
        logic        e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_ok(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timed out waiting for result", name);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.A  = a;
        bus.WD = d;
        bus.WE = 1'b1;
        tick();
        bus.WE = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.A = a;
        #1;
        d = bus.RD;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Poll res_empty until a result is available or the budget runs out
    task automatic wait_res(input int budget, output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            rd(3'd1, s);
            if (!s[0]) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // n! with overflow detection beyond 32 bits
    function automatic void model(input int n, output logic [31:0] v, output logic e);
        longint unsigned p = 1;
        for (int i = 2; i <= n; i++) p = p * longint'(i);
        e = (p >> 32) != 0;
        v = e ? 32'd0 : p[31:0];
    endfunction

    initial begin
        vec_t        tbl[8];
        logic [31:0] r;
        logic [31:0] mv;
        logic        me;
        bit          ok;
        int          q[$];
        int          got;

        bus.A = '0; bus.WE = 1'b0; bus.WD = '0; rst = 1'b0;

        tbl[0] = '{0, 32'd1, 1'b0};
        tbl[1] = '{1, 32'd1, 1'b0};
        tbl[2] = '{5, 32'd120, 1'b0};
        tbl[3] = '{7, 32'd5040, 1'b0};
        tbl[4] = '{10, 32'd3628800, 1'b0};
        tbl[5] = '{12, 32'd479001600, 1'b0};
        tbl[6] = '{13, 32'd0, 1'b1};
        tbl[7] = '{15, 32'd0, 1'b1};

        // Reset state
        do_reset();
        rd(3'd1, r); check("rst_status", r, 32'd5);
        rd(3'd0, r); check("rst_req_occ", r, 32'd0);
        rd(3'd2, r); check("rst_res_val", r, 32'd0);
        rd(3'd3, r); check("rst_res_err", r, 32'd0);
        check("rst_irq", 32'(bus.IRQ), 32'd0);

        // Latency: n=5 readable exactly 7 edges after the push edge
        wr(3'd0, 32'd5);
        repeat (6) tick();
        rd(3'd1, r); check("lat_not_early", 32'(r[0]), 32'd1);
        tick();
        rd(3'd1, r); check("lat_res_empty", 32'(r[0]), 32'd0);
        rd(3'd2, r); check("lat_val", r, 32'd120);
        rd(3'd3, r); check("lat_err", r, 32'd0);
        wr(3'd3, 32'd0);
        rd(3'd1, r); check("lat_popped", r, 32'd5);

        // Pop on empty result FIFO is ignored
        wr(3'd3, 32'd0);
        rd(3'd1, r); check("pop_empty_status", r, 32'd5);

        // Ordering: 0, 1, 12
        wr(3'd0, 32'd0); wr(3'd0, 32'd1); wr(3'd0, 32'd12);
        repeat (40) tick();
        rd(3'd0, r); check("ord_occ", r, 32'd0);
        rd(3'd2, r); check("ord0_val", r, 32'd1);
        rd(3'd3, r); check("ord0_err", r, 32'd0);
        wr(3'd3, 32'd0);
        rd(3'd2, r); check("ord1_val", r, 32'd1);
        rd(3'd3, r); check("ord1_err", r, 32'd0);
        wr(3'd3, 32'd0);
        rd(3'd2, r); check("ord2_val", r, 32'd479001600);
        rd(3'd3, r); check("ord2_err", r, 32'd0);
        wr(3'd3, 32'd0);

        // Table-driven single requests
        for (int i = 0; i < 8; i++) begin
            wr(3'd0, 32'(tbl[i].n));
            wait_res(40, ok);
            check_ok($sformatf("tbl%0d_wait", i), ok);
            rd(3'd2, r); check($sformatf("tbl%0d_val n=%0d", i, tbl[i].n), r, tbl[i].val);
            rd(3'd3, r); check($sformatf("tbl%0d_err n=%0d", i, tbl[i].n), r, 32'(tbl[i].e));
            wr(3'd3, 32'd0);
        end

        // Interrupt enable path
`ifdef FACT_ENGINE_IRQ_EN
        wr(3'd4, 32'd1);
        rd(3'd4, r); check("ie_read", r, 32'd1);
        wr(3'd0, 32'd3);
        wait_res(40, ok);
        check_ok("irq_wait", ok);
        tick();
        check("irq_set", 32'(bus.IRQ), 32'd1);
        wr(3'd3, 32'd0);
        tick();
        check("irq_clr", 32'(bus.IRQ), 32'd0);
`else
        wr(3'd4, 32'd1);
        rd(3'd4, r); check("ie_absent", r, 32'd0);
        wr(3'd0, 32'd3);
        wait_res(40, ok);
        check_ok("noirq_wait", ok);
        tick();
        check("irq_tied", 32'(bus.IRQ), 32'd0);
        wr(3'd3, 32'd0);
`endif

        // Reset mid-CALC, with a simultaneous push that reset must override
        wr(3'd0, 32'd15);
        repeat (3) tick();
        rd(3'd1, r); check("midcalc_busy", 32'(r[4]), 32'd1);
        bus.A = 3'd0; bus.WD = 32'd3; bus.WE = 1'b1; rst = 1'b1;
        tick();
        bus.WE = 1'b0; rst = 1'b0;
        rd(3'd1, r); check("midrst_status", r, 32'd5);
        rd(3'd0, r); check("midrst_occ", r, 32'd0);
        rd(3'd4, r); check("midrst_ie", r, 32'd0);
        check("midrst_irq", 32'(bus.IRQ), 32'd0);
        repeat (25) tick();
        rd(3'd1, r); check("midrst_no_result", r, 32'd5);

        // Overflow, backpressure and drop
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr(3'd0, 32'd2);
            repeat (6) tick();
        end
        rd(3'd1, r); check("bp_status", r, 32'd26);
        for (int i = 0; i < 5; i++) wr(3'd0, 32'd2);
        rd(3'd1, r); check("bp_drop_status", r, 32'd58);
        rd(3'd0, r); check("bp_req_occ", r, 32'd4);
        repeat (10) tick();
        rd(3'd1, r); check("bp_hold_done", r, 32'd58);
        rd(3'd2, r); check("bp_head", r, 32'd2);
        wr(3'd3, 32'd0);
        repeat (6) tick();
        rd(3'd0, r); check("bp_resume_occ", r, 32'd3);
        rd(3'd1, r); check("bp_resume_status", r, 32'd50);
        wr(3'd4, 32'd2);
        rd(3'd1, r); check("drop_cleared", r, 32'd18);

        // Push into a full request FIFO in the same cycle the FSM pops it
        wr(3'd0, 32'd2);
        rd(3'd0, r); check("fill_occ", r, 32'd4);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd2);
        rd(3'd0, r); check("same_cycle_occ", r, 32'd4);
        rd(3'd1, r); check("same_cycle_drop", 32'(r[5]), 32'd0);

        // Drain everything still queued
        got = 0;
        for (int i = 0; i < 12; i++) begin
            wait_res(30, ok);
            if (!ok) break;
            rd(3'd2, r); check($sformatf("drain%0d_val", i), r, 32'd2);
            wr(3'd3, 32'd0);
            got++;
        end
        check("drain_count", 32'(got), 32'd9);
        rd(3'd1, r); check("drain_idle", r, 32'd5);

        // Random traffic against the model
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if (q.size() < 6 && $urandom_range(1, 0) == 1) begin
                int n;
                n = $urandom_range(15, 0);
                q.push_back(n);
                wr(3'd0, 32'(n));
            end
            repeat ($urandom_range(8, 0)) tick();
            if ($urandom_range(1, 0) == 1) begin
                rd(3'd1, r);
                if (!r[0]) begin
                    check("rnd_spurious", 32'(q.size() > 0), 32'd1);
                    if (q.size() > 0) begin
                        model(q[0], mv, me);
                        rd(3'd2, r); check($sformatf("rnd_val n=%0d", q[0]), r, mv);
                        rd(3'd3, r); check($sformatf("rnd_err n=%0d", q[0]), r, 32'(me));
                        void'(q.pop_front());
                    end
                    wr(3'd3, 32'd0);
                end
            end
        end
        while (q.size() > 0) begin
            wait_res(60, ok);
            check_ok("rnd_drain_wait", ok);
            if (!ok) break;
            model(q[0], mv, me);
            rd(3'd2, r); check($sformatf("rnd_val n=%0d", q[0]), r, mv);
            rd(3'd3, r); check($sformatf("rnd_err n=%0d", q[0]), r, 32'(me));
            void'(q.pop_front());
            wr(3'd3, 32'd0);
        end
        repeat (20) tick();
        rd(3'd1, r); check("rnd_final_status", r, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
